// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths, slave address map and DMA master state encoding.
package bus_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam logic [7:0] S0_BASE = 8'h00;
    localparam logic [7:0] S1_BASE = 8'h20;
    localparam logic [7:0] REGION_SIZE = 8'h20;
    typedef enum logic [2:0] {IDLE, REQ, RD, RWAIT, WR, DONE} dma_state_t;
endpackage

// File: rtl/bus_dma_master.sv
// bus_dma_master: copies a block of bus words one at a time, read into a holding register then written.
module bus_dma_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int LEN_W = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_dout,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din
);
    import bus_pkg::*;
    dma_state_t state, state_n;
    logic [ADDR_W-1:0] src_r, src_n, dst_r, dst_n;
    logic [LEN_W-1:0] len_r, len_n, idx, idx_n;
    logic [1:0] wcnt, wcnt_n;
    logic [DATA_W-1:0] hold, hold_n;
    always_comb begin
        state_n = state;
        src_n = src_r;
        dst_n = dst_r;
        len_n = len_r;
        idx_n = idx;
        wcnt_n = wcnt;
        hold_n = hold;
        case (state)
            IDLE: if (start) begin
                src_n = src_addr;
                dst_n = dst_addr;
                len_n = len;
                idx_n = '0;
                state_n = (len == '0) ? DONE : REQ;
            end
            REQ: state_n = m_grant ? RD : REQ;
            RD: if (!m_grant) state_n = REQ;
                else if (READ_LATENCY == 0) begin
                    hold_n = m_din;
                    state_n = WR;
                end else begin
                    wcnt_n = 2'(READ_LATENCY - 1);
                    state_n = RWAIT;
                end
            RWAIT: if (!m_grant) state_n = REQ;
                else if (wcnt == 2'd0) begin
                    hold_n = m_din;
                    state_n = WR;
                end else wcnt_n = wcnt - 2'd1;
            // a write without grant did not happen, so the word restarts from its read
            WR: if (!m_grant) state_n = REQ;
                else if (idx == len_r - LEN_W'(1)) state_n = DONE;
                else begin
                    idx_n = idx + LEN_W'(1);
                    state_n = RD;
                end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            src_r <= '0;
            dst_r <= '0;
            len_r <= '0;
            idx <= '0;
            wcnt <= '0;
            hold <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            m_req <= 1'b0;
            m_wr <= 1'b0;
            m_address <= '0;
            m_dout <= '0;
        end else begin
            state <= state_n;
            src_r <= src_n;
            dst_r <= dst_n;
            len_r <= len_n;
            idx <= idx_n;
            wcnt <= wcnt_n;
            hold <= hold_n;
            busy <= state_n inside {REQ, RD, RWAIT, WR};
            done <= state_n == DONE;
            m_req <= state_n inside {REQ, RD, RWAIT, WR};
            m_wr <= state_n == WR;
            m_address <= (state_n == RD || state_n == RWAIT) ? src_n + ADDR_W'(idx_n) :
                         (state_n == WR) ? dst_n + ADDR_W'(idx_n) : '0;
            m_dout <= (state_n == WR) ? hold_n : '0;
        end
    end
endmodule

// File: tb/tb_bus_dma_master.sv
// tb_bus_dma_master: drives the DMA master against a bus/memory model and checks every cycle against a word-level reference.
module tb_bus_dma_master;
    localparam int LAT = 1;
    logic clk = 1'b0;
    logic reset, start, busy, done, m_req, m_wr, m_grant;
    logic [7:0] src_addr, dst_addr, m_address;
    logic [4:0] len;
    logic [63:0] m_dout, m_din;
    always #5 clk = ~clk;
    bus_dma_master #(.ADDR_W(8), .DATA_W(64), .LEN_W(5), .READ_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .m_req(m_req), .m_wr(m_wr),
        .m_address(m_address), .m_dout(m_dout), .m_grant(m_grant), .m_din(m_din)
    );
    logic [63:0] mem [256];
    logic [63:0] snap [32];
    int tests, fails, cyc;
    bit active, done_due, exp_req;
    int k, rd_left, m_len;
    logic [7:0] m_src, m_dst;
    int hold_cnt, drop_cnt, drop_pct, drop_word;
    int done_cnt, wr_cnt, req_cnt, start_cyc, done_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected bus behaviour: a word needs one granted REQ, LAT+1 granted read cycles and one granted write.
    task automatic compare();
        logic ew;
        logic [7:0] ea;
        ew = active && !exp_req && rd_left == 0;
        ea = (!active || exp_req) ? 8'h00 : (rd_left > 0) ? 8'(m_src + 8'(k)) : 8'(m_dst + 8'(k));
        chk("done", done, done_due);
        chk("busy", busy, active);
        chk("m_req", m_req, active);
        chk("m_wr", m_wr, ew);
        chk("m_address", m_address, ea);
        chk("m_dout", m_dout, ew ? snap[k] : 64'h0);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (m_wr) wr_cnt++;
        if (m_req) req_cnt++;
    endtask

    task automatic tick();
        logic fire, g, nd;
        logic [7:0] a;
        logic [63:0] d;
        fire = m_req && m_grant && m_wr;
        a = m_address;
        d = m_dout;
        g = m_grant;
        nd = 1'b0;
        if (active) begin
            if (exp_req) begin
                if (g) begin
                    exp_req = 1'b0;
                    rd_left = LAT + 1;
                end
            end else if (!g) exp_req = 1'b1;
            else if (rd_left > 0) rd_left--;
            else begin
                k++;
                if (k == m_len) begin
                    active = 1'b0;
                    nd = 1'b1;
                end else rd_left = LAT + 1;
            end
        end else if (start && !done_due && !reset) begin
            m_src = src_addr;
            m_dst = dst_addr;
            m_len = int'(len);
            k = 0;
            start_cyc = cyc;
            for (int i = 0; i < 32; i++) snap[i] = mem[8'(src_addr + 8'(i))];
            if (len == 5'd0) nd = 1'b1;
            else begin
                active = 1'b1;
                exp_req = 1'b1;
            end
        end
        done_due = nd;
        @(posedge clk);
        #1;
        cyc++;
        if (fire) mem[a] = d;
        m_din = mem[a];
        start = 1'b0;
        compare();
        if (drop_word >= 0 && m_wr && k == drop_word) begin
            drop_cnt = 2;
            drop_word = -1;
        end
        m_grant = m_req && hold_cnt == 0 && drop_cnt == 0 && ($urandom_range(99) >= drop_pct);
        if (hold_cnt > 0) hold_cnt--;
        if (drop_cnt > 0) drop_cnt--;
    endtask

    task automatic run(input logic [7:0] s, input logic [7:0] dd, input logic [4:0] l);
        int n;
        done_cnt = 0;
        wr_cnt = 0;
        req_cnt = 0;
        src_addr = s;
        dst_addr = dd;
        len = l;
        start = 1'b1;
        tick();
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            tick();
            n++;
        end
        chk("done_timeout", done_cnt != 0, 1'b1);
        tick();
        chk("done_once", done_cnt, 1);
        for (int i = 0; i < int'(l); i++) chk("dst_data", mem[8'(dd + 8'(i))], snap[i]);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        active = 0; done_due = 0; exp_req = 0; k = 0; rd_left = 0; m_len = 0;
        m_src = 0; m_dst = 0; hold_cnt = 0; drop_cnt = 0; drop_pct = 0; drop_word = -1;
        reset = 1'b1; start = 1'b0; src_addr = 0; dst_addr = 0; len = 0;
        m_grant = 1'b0; m_din = 64'h0;
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        for (int i = 0; i < 32; i++) snap[i] = 64'h0;
        #1;
        chk("reset_req", m_req, 1'b0);
        chk("reset_busy", busy, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        // basic copy, grant always available
        mem[8'h00] = 64'd1; mem[8'h01] = 64'd2; mem[8'h02] = 64'd4; mem[8'h03] = 64'd6;
        run(8'h00, 8'h20, 5'd4);
        chk("basic_s1_20", mem[8'h20], 64'd1);
        chk("basic_s1_21", mem[8'h21], 64'd2);
        chk("basic_s1_22", mem[8'h22], 64'd4);
        chk("basic_s1_23", mem[8'h23], 64'd6);
        chk("basic_done_latency", done_cyc - start_cyc, 14);
        chk("basic_wr_cycles", wr_cnt, 4);
        // zero length
        run(8'h05, 8'h25, 5'd0);
        chk("len0_done_latency", done_cyc - start_cyc, 1);
        chk("len0_no_req", req_cnt, 0);
        // other master holds the bus for 10 cycles
        for (int i = 0; i < 4; i++) mem[8'h08 + 8'(i)] = 64'hA0 + 64'(i);
        hold_cnt = 10;
        run(8'h08, 8'h30, 5'd4);
        chk("contention_latency", done_cyc - start_cyc, 24);
        chk("contention_last", mem[8'h33], 64'hA3);
        // grant lost for two cycles during the write of word 2
        for (int i = 0; i < 4; i++) mem[8'h10 + 8'(i)] = 64'hB0 + 64'(i);
        drop_word = 2;
        run(8'h10, 8'h28, 5'd4);
        chk("drop_latency", done_cyc - start_cyc, 19);
        chk("drop_word2", mem[8'h2A], 64'hB2);
        chk("drop_wr_cycles", wr_cnt, 5);
        // address wrap with a second start while busy
        mem[8'hFE] = 64'hDEAD_0001; mem[8'hFF] = 64'hDEAD_0002; mem[8'h00] = 64'hDEAD_0003;
        done_cnt = 0;
        wr_cnt = 0;
        src_addr = 8'hFE; dst_addr = 8'h40; len = 5'd3;
        start = 1'b1;
        tick();
        repeat (3) tick();
        src_addr = 8'h10; dst_addr = 8'h60; len = 5'd5;
        start = 1'b1;
        tick();
        for (int n = 0; n < 100 && done_cnt == 0; n++) tick();
        repeat (3) tick();
        chk("wrap_done_once", done_cnt, 1);
        chk("wrap_40", mem[8'h40], 64'hDEAD_0001);
        chk("wrap_41", mem[8'h41], 64'hDEAD_0002);
        chk("wrap_42", mem[8'h42], 64'hDEAD_0003);
        chk("wrap_no_extra", mem[8'h60], 64'h0);
        // reset during the read wait of word 1
        src_addr = 8'h00; dst_addr = 8'h50; len = 5'd4;
        start = 1'b1;
        tick();
        for (int n = 0; n < 50 && !(active && k == 1 && !exp_req && rd_left == 1); n++) tick();
        chk("reached_rwait1", active && k == 1 && !exp_req && rd_left == 1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_req", m_req, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_wr", m_wr, 1'b0);
        active = 0; done_due = 0; exp_req = 0;
        m_grant = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        mem[8'h04] = 64'h1234;
        run(8'h04, 8'h58, 5'd1);
        chk("post_reset_copy", mem[8'h58], 64'h1234);
        // randomized transfers with random grant loss
        drop_pct = 15;
        for (int t = 0; t < 10; t++) begin
            logic [7:0] s;
            s = 8'($urandom_range(255));
            for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
            hold_cnt = $urandom_range(5);
            run(s, 8'(s + 8'h80), 5'($urandom_range(31)));
        end
        drop_pct = 0;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
